// File: rtl/ifu_lsu_mem_arbiter.sv
// Arbitrates IFU fetches and LSU accesses onto one memory port and routes in-order responses back by tag.
// Optional macro ARB_STARVE_GUARD_EN: forces an IFU grant after MAX_WAIT consecutive LSU grants.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

module ifu_lsu_mem_arbiter #(
  parameter int unsigned OUTS_DEPTH = 2,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [`PC_SIZE-1:0]     ifu_req_pc,
  output logic                    ifu_rsp_valid,
  input  logic                    ifu_rsp_ready,
  output logic [`INSTR_SIZE-1:0]  ifu_rsp_instr,
  output logic                    ifu_rsp_err,
  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [`XLEN-1:0]        lsu_req_addr,
  input  logic                    lsu_req_write,
  input  logic [`XLEN-1:0]        lsu_req_wdata,
  input  logic [`XLEN/8-1:0]      lsu_req_wmask,
  output logic                    lsu_rsp_valid,
  input  logic                    lsu_rsp_ready,
  output logic [`XLEN-1:0]        lsu_rsp_rdata,
  output logic                    lsu_rsp_err,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [`XLEN-1:0]        mem_req_addr,
  output logic                    mem_req_write,
  output logic [`XLEN-1:0]        mem_req_wdata,
  output logic [`XLEN/8-1:0]      mem_req_wmask,
  input  logic                    mem_rsp_valid,
  output logic                    mem_rsp_ready,
  input  logic [`XLEN-1:0]        mem_rsp_rdata,
  input  logic                    mem_rsp_err
);

  localparam int unsigned PTR_W = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(OUTS_DEPTH + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state_q, state_d;
  logic               held_lsu_q;
  logic               sel_lsu;
  logic               force_ifu;
  logic [OUTS_DEPTH-1:0] tag_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               full, empty, head_lsu;
  logic               push, pop;

  assign full     = (count_q == CNT_W'(OUTS_DEPTH));
  assign empty    = (count_q == '0);
  assign head_lsu = tag_q[rd_ptr_q];
  assign push     = mem_req_valid && mem_req_ready;
  assign pop      = mem_rsp_valid && mem_rsp_ready && !empty;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt_q;

  assign force_ifu = ifu_req_valid && (starve_cnt_q >= 4'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else if (!ifu_req_valid || ifu_req_ready) begin
      starve_cnt_q <= '0;
    end else if (lsu_req_ready && starve_cnt_q != 4'hf) begin
      starve_cnt_q <= starve_cnt_q + 4'd1;
    end
  end
`else
  assign force_ifu = 1'b0;
`endif

  // Request side: in HOLD the registered owner keeps the port regardless of new arrivals
  always_comb begin
    state_d = state_q;
    if (state_q == HOLD) begin
      sel_lsu = held_lsu_q;
    end else begin
      sel_lsu = lsu_req_valid && !force_ifu;
    end

    mem_req_valid = !full && (sel_lsu ? lsu_req_valid : ifu_req_valid);
    if (sel_lsu) begin
      mem_req_addr  = lsu_req_addr;
      mem_req_write = lsu_req_write;
      mem_req_wdata = lsu_req_wdata;
      mem_req_wmask = lsu_req_wmask;
    end else begin
      mem_req_addr  = `XLEN'(ifu_req_pc);
      mem_req_write = 1'b0;
      mem_req_wdata = '0;
      mem_req_wmask = '1;
    end
    ifu_req_ready = mem_req_valid && !sel_lsu && mem_req_ready;
    lsu_req_ready = mem_req_valid &&  sel_lsu && mem_req_ready;

    case (state_q)
      IDLE:    if (mem_req_valid && !mem_req_ready) state_d = HOLD;
      HOLD:    if (push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      held_lsu_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) held_lsu_q <= sel_lsu;
    end
  end

  // Response side: an empty FIFO sinks stray responses
  always_comb begin
    ifu_rsp_valid = mem_rsp_valid && !empty && !head_lsu;
    lsu_rsp_valid = mem_rsp_valid && !empty &&  head_lsu;
    ifu_rsp_instr = mem_rsp_rdata[`INSTR_SIZE-1:0];
    ifu_rsp_err   = mem_rsp_err;
    lsu_rsp_rdata = mem_rsp_rdata;
    lsu_rsp_err   = mem_rsp_err;
    if (empty) mem_rsp_ready = 1'b1;
    else       mem_rsp_ready = head_lsu ? lsu_rsp_ready : ifu_rsp_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= sel_lsu;
        wr_ptr_q <= (wr_ptr_q == PTR_W'(OUTS_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(OUTS_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_lsu_mem_arbiter.sv
// Scoreboard bench for ifu_lsu_mem_arbiter: stimulus pushes expected requests/responses, a negedge monitor pops and compares.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

module tb_ifu_lsu_mem_arbiter;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   ifu_req_valid, ifu_req_ready;
  logic [`PC_SIZE-1:0]    ifu_req_pc;
  logic                   ifu_rsp_valid, ifu_rsp_ready;
  logic [`INSTR_SIZE-1:0] ifu_rsp_instr;
  logic                   ifu_rsp_err;
  logic                   lsu_req_valid, lsu_req_ready;
  logic [`XLEN-1:0]       lsu_req_addr, lsu_req_wdata;
  logic                   lsu_req_write;
  logic [`XLEN/8-1:0]     lsu_req_wmask;
  logic                   lsu_rsp_valid, lsu_rsp_ready;
  logic [`XLEN-1:0]       lsu_rsp_rdata;
  logic                   lsu_rsp_err;
  logic                   mem_req_valid, mem_req_ready;
  logic [`XLEN-1:0]       mem_req_addr, mem_req_wdata;
  logic                   mem_req_write;
  logic [`XLEN/8-1:0]     mem_req_wmask;
  logic                   mem_rsp_valid, mem_rsp_ready;
  logic [`XLEN-1:0]       mem_rsp_rdata;
  logic                   mem_rsp_err;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct {
    logic        lsu;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  typedef struct {
    logic        lsu;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  req_t me;
  rsp_t mr;

  always #5 clk = ~clk;

  ifu_lsu_mem_arbiter #(.OUTS_DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_write(lsu_req_write), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
    .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_write(mem_req_write), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic lsu, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wdata, input logic [3:0] wmask);
    req_t r;
    r.lsu = lsu; r.addr = addr; r.wr = wr; r.wdata = wdata; r.wmask = wmask;
    req_q.push_back(r);
  endtask

  task automatic push_rsp(input logic lsu, input logic [31:0] data, input logic err);
    rsp_t r;
    r.lsu = lsu; r.data = data; r.err = err;
    rsp_q.push_back(r);
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 0; ifu_req_pc = '0; ifu_rsp_ready = 0;
    lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_write = 0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    lsu_rsp_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0; mem_rsp_err = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lsu_rd(input logic [31:0] addr);
    lsu_req_valid = 1; lsu_req_addr = addr; lsu_req_write = 0; lsu_req_wdata = '0; lsu_req_wmask = 4'hf;
  endtask

  // Monitor: every request/response handshake must match the head of its scoreboard queue
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_req_valid && mem_req_ready) begin
        vectors++;
        if (req_q.size() == 0) begin
          miscompares++;
          $display("FAIL mem_req_unexpected: got addr %h, expected no request", mem_req_addr);
        end else begin
          me = req_q.pop_front();
          if (lsu_req_ready !== me.lsu || ifu_req_ready !== !me.lsu || mem_req_addr !== me.addr ||
              mem_req_write !== me.wr || mem_req_wmask !== me.wmask ||
              (me.wr && mem_req_wdata !== me.wdata)) begin
            miscompares++;
            $display("FAIL mem_req: got lsu=%b ifu=%b addr=%h wr=%b wdata=%h wmask=%h expected lsu=%b addr=%h wr=%b wdata=%h wmask=%h",
                     lsu_req_ready, ifu_req_ready, mem_req_addr, mem_req_write, mem_req_wdata, mem_req_wmask,
                     me.lsu, me.addr, me.wr, me.wdata, me.wmask);
          end
        end
      end
      if ((ifu_rsp_valid && ifu_rsp_ready) || (lsu_rsp_valid && lsu_rsp_ready)) begin
        vectors++;
        if (rsp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rsp_unexpected: got ifu_v=%b lsu_v=%b, expected no response", ifu_rsp_valid, lsu_rsp_valid);
        end else begin
          mr = rsp_q.pop_front();
          if (mr.lsu ? (!lsu_rsp_valid || ifu_rsp_valid || lsu_rsp_rdata !== mr.data || lsu_rsp_err !== mr.err)
                     : (!ifu_rsp_valid || lsu_rsp_valid || ifu_rsp_instr !== mr.data || ifu_rsp_err !== mr.err)) begin
            miscompares++;
            $display("FAIL rsp: got ifu_v=%b instr=%h ierr=%b lsu_v=%b rdata=%h lerr=%b expected lsu=%b data=%h err=%b",
                     ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
                     mr.lsu, mr.data, mr.err);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic prev_lsu;
    logic cur_lsu;
    idle_inputs();
    rst_n = 0;
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 0);
    chk("rst_ifu_req_ready", 32'(ifu_req_ready), 0);
    chk("rst_lsu_req_ready", 32'(lsu_req_ready), 0);
    chk("rst_ifu_rsp_valid", 32'(ifu_rsp_valid), 0);
    chk("rst_lsu_rsp_valid", 32'(lsu_rsp_valid), 0);
    cyc();
    rst_n = 1;

    // LSU beats IFU; IFU next; FIFO then full
    ifu_req_valid = 1; ifu_req_pc = 32'h80; lsu_rd(32'h100); mem_req_ready = 1;
    push_req(1, 32'h100, 0, 0, 4'hf);
    @(negedge clk);
    chk("prio_lsu_ready", 32'(lsu_req_ready), 1);
    chk("prio_ifu_ready", 32'(ifu_req_ready), 0);
    chk("prio_addr", mem_req_addr, 32'h100);
    cyc(); lsu_req_valid = 0;
    push_req(0, 32'h80, 0, 0, 4'hf);
    @(negedge clk);
    chk("ifu_second_ready", 32'(ifu_req_ready), 1);
    cyc(); ifu_req_pc = 32'hC0;
    @(negedge clk);
    chk("full_valid", 32'(mem_req_valid), 0);
    cyc(); mem_rsp_valid = 1; mem_rsp_rdata = 32'h11112222; ifu_rsp_ready = 1; lsu_rsp_ready = 1;
    push_rsp(1, 32'h11112222, 0);
    @(negedge clk);
    chk("full_no_bypass", 32'(mem_req_valid), 0);
    chk("route_lsu_valid", 32'(lsu_rsp_valid), 1);
    cyc(); ifu_req_valid = 0; mem_rsp_rdata = 32'h33334444;
    push_rsp(0, 32'h33334444, 0);
    @(negedge clk);
    chk("route_ifu_mem_ready", 32'(mem_rsp_ready), 1);
    cyc(); idle_inputs();

    // IFU held through backpressure while LSU arrives
    ifu_req_valid = 1; ifu_req_pc = 32'h40;
    @(negedge clk);
    chk("hold_addr_c1", mem_req_addr, 32'h40);
    cyc(); lsu_req_valid = 1; lsu_req_addr = 32'h200; lsu_req_write = 1;
    lsu_req_wdata = 32'hDEADBEEF; lsu_req_wmask = 4'h3;
    @(negedge clk);
    chk("hold_addr_c2", mem_req_addr, 32'h40);
    chk("hold_lsu_ready", 32'(lsu_req_ready), 0);
    cyc();
    @(negedge clk);
    chk("hold_addr_c3", mem_req_addr, 32'h40);
    cyc(); mem_req_ready = 1;
    push_req(0, 32'h40, 0, 0, 4'hf);
    @(negedge clk);
    cyc(); ifu_req_valid = 0;
    push_req(1, 32'h200, 1, 32'hDEADBEEF, 4'h3);
    @(negedge clk);
    cyc(); lsu_req_valid = 0; ifu_req_valid = 1; ifu_req_pc = 32'h300;
    @(negedge clk);
    chk("full_ifu_ready", 32'(ifu_req_ready), 0);

    // In-order responses; LSU error held off by lsu_rsp_ready
    cyc(); ifu_req_valid = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'hAAAA0001; mem_rsp_err = 0;
    ifu_rsp_ready = 1; lsu_rsp_ready = 0;
    push_rsp(0, 32'hAAAA0001, 0);
    @(negedge clk);
    cyc(); mem_rsp_rdata = 32'hBBBB0002; mem_rsp_err = 1;
    @(negedge clk);
    chk("bp_mem_rsp_ready_1", 32'(mem_rsp_ready), 0);
    chk("bp_lsu_rsp_valid", 32'(lsu_rsp_valid), 1);
    cyc();
    @(negedge clk);
    chk("bp_mem_rsp_ready_2", 32'(mem_rsp_ready), 0);
    cyc(); lsu_rsp_ready = 1;
    push_rsp(1, 32'hBBBB0002, 1);
    @(negedge clk);
    chk("err_lsu_rsp_err", 32'(lsu_rsp_err), 1);
    cyc(); idle_inputs();

    // Reset with two outstanding, then stray response is sunk
    lsu_rd(32'h400); mem_req_ready = 1;
    push_req(1, 32'h400, 0, 0, 4'hf);
    cyc(); lsu_req_valid = 0; ifu_req_valid = 1; ifu_req_pc = 32'h500;
    push_req(0, 32'h500, 0, 0, 4'hf);
    cyc(); idle_inputs(); rst_n = 0;
    cyc(); rst_n = 1; mem_rsp_valid = 1; mem_rsp_rdata = 32'h12345678;
    @(negedge clk);
    chk("stray_mem_rsp_ready", 32'(mem_rsp_ready), 1);
    chk("stray_ifu_rsp_valid", 32'(ifu_rsp_valid), 0);
    chk("stray_lsu_rsp_valid", 32'(lsu_rsp_valid), 0);
    cyc();
    @(negedge clk);
    chk("stray_mem_rsp_ready_2", 32'(mem_rsp_ready), 1);
    cyc(); mem_rsp_valid = 0; ifu_req_valid = 1; ifu_req_pc = 32'h600; mem_req_ready = 1;
    push_req(0, 32'h600, 0, 0, 4'hf);
    cyc(); ifu_req_valid = 0; lsu_rd(32'h604);
    push_req(1, 32'h604, 0, 0, 4'hf);
    cyc(); lsu_req_valid = 0; ifu_req_valid = 1; ifu_req_pc = 32'h700;
    @(negedge clk);
    chk("post_rst_full", 32'(mem_req_valid), 0);
    cyc(); ifu_req_valid = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'hC0DE0600;
    ifu_rsp_ready = 1; lsu_rsp_ready = 1;
    push_rsp(0, 32'hC0DE0600, 0);
    cyc(); mem_rsp_rdata = 32'hC0DE0604;
    push_rsp(1, 32'hC0DE0604, 0);
    cyc(); idle_inputs();

    // Continuous contention; one response per cycle keeps the FIFO from filling
    prev_lsu = 0;
    ifu_rsp_ready = 1; lsu_rsp_ready = 1; mem_req_ready = 1;
`ifdef ARB_STARVE_GUARD_EN
    for (int k = 0; k < 10; k++) begin
      cur_lsu = ((k % 5) != 4);
`else
    for (int k = 0; k < 4; k++) begin
      cur_lsu = 1'b1;
`endif
      ifu_req_valid = 1; ifu_req_pc = 32'h80; lsu_rd(32'h100);
      push_req(cur_lsu, cur_lsu ? 32'h100 : 32'h80, 0, 0, 4'hf);
      if (k >= 1) begin
        mem_rsp_valid = 1; mem_rsp_rdata = 32'h5000 + 32'(k - 1);
        push_rsp(prev_lsu, 32'h5000 + 32'(k - 1), 0);
      end
      @(negedge clk);
      chk("contend_lsu_ready", 32'(lsu_req_ready), 32'(cur_lsu));
      prev_lsu = cur_lsu;
      cyc();
    end
    ifu_req_valid = 0; lsu_req_valid = 0; mem_rsp_valid = 1;
`ifdef ARB_STARVE_GUARD_EN
    mem_rsp_rdata = 32'h5009;
    push_rsp(prev_lsu, 32'h5009, 0);
`else
    mem_rsp_rdata = 32'h5003;
    push_rsp(prev_lsu, 32'h5003, 0);
`endif
    cyc(); idle_inputs();
    repeat (3) cyc();

    vectors++;
    if (req_q.size() != 0 || rsp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d requests and %0d responses pending, expected 0 and 0", req_q.size(), rsp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifu_lsu_mem_arbiter.md
Name: ifu_lsu_mem_arbiter

Overview:
- Shares the single core memory port between IFU instruction fetch (ifu_req_*/ifu_rsp_*) and LSU load/store (lsu_req_*/lsu_rsp_*).
- Arbitrates requests and holds the grant stable across backpressure.
- Tracks outstanding transactions in an in-order tag FIFO and routes each response back to its originator.
- Sits between ifu_ifetch / the LSU and the memory/BIU interface.

Parameters:
- OUTS_DEPTH, 2: maximum outstanding memory transactions. Power of 2, minimum 1.
- MAX_WAIT, 4: consecutive LSU grants while IFU waits before IFU is forced (see Optional Feature). Range 1..15.

Ports:
- clk in 1: core clock
- rst_n in 1: asynchronous active-low reset
- ifu_req_valid in 1: fetch request
- ifu_req_ready out 1: fetch request accepted
- ifu_req_pc in `PC_SIZE: fetch address
- ifu_rsp_valid out 1: fetch response valid
- ifu_rsp_ready in 1: IFU can take response
- ifu_rsp_instr out `INSTR_SIZE: fetched instruction
- ifu_rsp_err out 1: fetch bus error
- lsu_req_valid in 1: load/store request
- lsu_req_ready out 1: LSU request accepted
- lsu_req_addr in `XLEN: LSU address
- lsu_req_write in 1: 1 = store
- lsu_req_wdata in `XLEN: store data
- lsu_req_wmask in `XLEN/8: byte enables
- lsu_rsp_valid out 1: LSU response valid
- lsu_rsp_ready in 1: LSU can take response
- lsu_rsp_rdata out `XLEN: load data
- lsu_rsp_err out 1: LSU bus error
- mem_req_valid out 1: memory request valid
- mem_req_ready in 1: memory accepts request
- mem_req_addr out `XLEN: memory address
- mem_req_write out 1: 1 = write
- mem_req_wdata out `XLEN: write data
- mem_req_wmask out `XLEN/8: byte enables
- mem_rsp_valid in 1: memory response valid
- mem_rsp_ready out 1: arbiter takes response
- mem_rsp_rdata in `XLEN: read data
- mem_rsp_err in 1: bus error

Behaviour:
- Reset (async, rst_n low):
  - Tag FIFO empty; grant state IDLE; starvation counter 0.
  - mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid and lsu_rsp_valid are all 0.
- States:
  - IDLE: no pending unaccepted request.
  - HOLD: a request was presented and not yet accepted. The held grant is registered as 1 bit: 0 = IFU, 1 = LSU.
- Arbitration in IDLE (combinational, same cycle), when the FIFO is not full:
  - LSU has priority over IFU.
  - The winner's fields drive mem_req_*.
  - mem_req_valid = winner's valid.
  - winner_req_ready = mem_req_ready. The loser's ready is 0.
- IDLE -> HOLD:
  - When mem_req_valid=1 and mem_req_ready=0.
  - In HOLD, mem_req_* is driven from the held requester only. A newly arriving higher-priority request must not switch the grant.
- HOLD -> IDLE on the mem request handshake.
- Tag FIFO full:
  - mem_req_valid = 0 and both req_ready = 0.
  - No push-while-pop bypass: a full FIFO blocks even in a cycle with a pop.
- IFU address conversion: mem_req_addr is ifu_req_pc zero-extended/truncated to `XLEN. mem_req_write = 0. mem_req_wmask = all ones.
- Tag FIFO:
  - Push the requester tag on each mem request handshake.
  - Pop on each mem response handshake.
  - Responses are strictly in order. Response latency through the arbiter is 0 cycles (combinational routing).
- Response routing by FIFO head tag:
  - Tag IFU: ifu_rsp_valid = mem_rsp_valid; mem_rsp_ready = ifu_rsp_ready; ifu_rsp_instr = mem_rsp_rdata[`INSTR_SIZE-1:0]; ifu_rsp_err = mem_rsp_err.
  - Tag LSU: equivalent routing to the lsu_rsp_* ports.
  - The non-selected rsp_valid is 0.
- Push and pop in the same cycle: count unchanged, pointers both advance, wrap modulo OUTS_DEPTH.
- Stray response (mem_rsp_valid while FIFO empty, e.g. after reset mid-transaction):
  - mem_rsp_ready = 1; response dropped; no requester rsp_valid.
- Reset mid-operation discards all outstanding tags. Memory-side responses still in flight afterwards are sunk by the stray-response rule.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- When defined:
  - A 4-bit counter increments on each LSU grant handshake while ifu_req_valid=1.
  - It clears on any IFU handshake, or when ifu_req_valid=0.
  - When counter ≥ MAX_WAIT, IFU wins IDLE arbitration over LSU.
- When undefined: the counter is absent and LSU priority is fixed; IFU may starve under continuous LSU traffic.

Test Plan:
- Simultaneous ifu_req_valid=1 and lsu_req_valid=1 (addr 0x100, read), mem_req_ready=1 → mem_req_addr=0x100, lsu_req_ready=1, ifu_req_ready=0; next cycle with LSU idle, IFU pc 0x80 is granted.
- IFU request pc 0x40, mem_req_ready=0 for 3 cycles, LSU asserts request in cycle 2 → mem_req_addr stays 0x40 through acceptance; LSU is granted only afterwards.
- OUTS_DEPTH=2, two accepted requests (IFU then LSU), no responses → third request sees ready=0. Responses 0xAAAA0001 then 0xBBBB0002 → appear on ifu_rsp_instr then lsu_rsp_rdata, in order.
- LSU response with mem_rsp_err=1 and lsu_rsp_ready=0 for 2 cycles → mem_rsp_ready=0 and FIFO not popped; on ready, lsu_rsp_err=1 and the FIFO pops.
- Assert rst_n=0 with 2 outstanding transactions, release, then mem_rsp_valid=1 → mem_rsp_ready=1, ifu_rsp_valid=lsu_rsp_valid=0, count stays 0.
- With ARB_STARVE_GUARD_EN, MAX_WAIT=4, both requesting continuously, mem_req_ready=1 → grant sequence LSU×4, IFU, LSU×4, IFU.
